alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_seq_if.sv | 24 ++
 rtl/mul_iter.sv | 55 +++++
 rtl/alu_seq.sv | 113 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state encoding for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OpAdd = 4'b1010;
    localparam logic [3:0] OpSub = 4'b1011;
    localparam logic [3:0] OpMul = 4'b1100;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StMulRun = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between an ALU client (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] A_bus;
    logic [WIDTH-1:0] B_bus;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] C_bus;
    logic             Z;
    logic             CO;

    modport master (
        output start, op, A_bus, B_bus,
        input  busy, done, C_bus, Z, CO
    );

    modport slave (
        input  start, op, A_bus, B_bus,
        output busy, done, C_bus, Z, CO
    );
endinterface

// File: rtl/mul_iter.sv
// Shift-add multiplier, one multiplier bit per cycle; bit 0 is folded into the load edge
// so the product is ready WIDTH-1 edges after load and can be consumed on edge WIDTH.
module mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CntW-1:0]    cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            product  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                product  <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                mcand_q  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                mplier_q <= b >> 1;
                cnt_q    <= CntW'(1);
                busy     <= 1'b1;
            end else if (busy) begin
                if (mplier_q[0]) begin
                    product <= product + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                if (cnt_q == CntLast) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-edge ADD/SUB/DBL, WIDTH-cycle iterative MUL, registered result/flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);

    state_e             state_q;
    logic [WIDTH-1:0]   c_q;
    logic               z_q;
    logic               co_q;
    logic               busy_q;
    logic               done_q;

    logic               accept;
    logic               mul_load;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     dbl;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_co;

    assign accept   = bus.start && (state_q == StIdle) && !mul_busy;
    assign mul_load = accept && (bus.op == OpMul);

    assign sum  = {1'b0, bus.A_bus} + {1'b0, bus.B_bus};
    assign diff = {1'b0, bus.A_bus} - {1'b0, bus.B_bus};
    assign dbl  = {1'b0, bus.A_bus} + {1'b0, bus.A_bus};

    // Top bit of the WIDTH+1 difference is the borrow (A < B).
    always_comb begin
        alu_res = dbl[WIDTH-1:0];
        alu_co  = dbl[WIDTH];
        case (bus.op)
            OpAdd: begin
                alu_res = sum[WIDTH-1:0];
                alu_co  = sum[WIDTH];
            end
            OpSub: begin
                alu_res = diff[WIDTH-1:0];
                alu_co  = diff[WIDTH];
            end
            default: ;
        endcase
    end

    mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (mul_load),
        .a      (bus.A_bus),
        .b      (bus.B_bus),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            c_q     <= '0;
            z_q     <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (bus.op == OpMul) begin
                            state_q <= StMulRun;
                            busy_q  <= 1'b1;
                        end else begin
                            c_q    <= alu_res;
                            z_q    <= (alu_res == '0);
                            co_q   <= alu_co;
                            done_q <= 1'b1;
                        end
                    end
                end
                StMulRun: begin
                    if (mul_done) begin
                        c_q     <= mul_product[WIDTH-1:0];
                        z_q     <= (mul_product[WIDTH-1:0] == '0);
                        co_q    <= |mul_product[2*WIDTH-1:WIDTH];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.C_bus = c_q;
    assign bus.Z     = z_q;
    assign bus.CO    = co_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
